dot_accumulator: RTL and testbench
==================================

Name: dot_accumulator

Overview:
- Downstream stage of the 4-input adder tree in the INT8 vector-MAC datapath.
- Sums the tree's per-cycle partial sums over a vector, delimited by a last flag, into one dot-product result.
- Results are buffered in a 2-entry output FIFO with a valid/ready handshake. The upstream tree has no backpressure, so overruns are flagged rather than stalled.

Parameters:
- W_IN, 18, width of the incoming partial sum (two's complement, sign-extended on entry).
- MAX_BEATS, 64, maximum beats per vector; must be a power of two and at least 2.
- CNT_W, 7, width of the beat counter; equals log2(MAX_BEATS)+1.
- W_ACC, W_IN+CNT_W-1 (24), accumulator/result width; guarantees no overflow for MAX_BEATS beats.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  partial sum valid; from adder tree out_valid.
- in_data  in  W_IN  partial sum; from adder tree sum.
- in_last  in  1  this beat closes the vector; qualified by in_valid.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts head when out_valid&out_ready.
- out_data  out  W_ACC  dot-product result at FIFO head.
- out_beats  out  CNT_W  number of beats summed into out_data (1..MAX_BEATS).
- overrun  out  1  sticky: a result was dropped because the FIFO was full.
- len_err  out  1  sticky: a vector reached MAX_BEATS without in_last.
- err_clr  in  1  synchronous clear of overrun and len_err.

Behaviour:
- Reset (async, rst_n=0): acc=0, beat_cnt=0, FIFO empty, out_valid=0, out_data=0, out_beats=0, overrun=0, len_err=0. Reset mid-vector discards the partial accumulation and any FIFO contents.
- Accumulate on every cycle with in_valid=1:
  - nxt = (beat_cnt==0 ? 0 : acc) + sext(in_data).
  - Count: beat_cnt+1.
  - in_valid=0 cycles are bubbles: acc and beat_cnt hold.
- Close: the beat closes the vector if in_last=1, or if beat_cnt+1==MAX_BEATS.
  - Forced close (MAX_BEATS reached, in_last=0): also sets len_err.
  - On close: push {nxt, beat_cnt+1} into the FIFO, then set beat_cnt=0. acc need not be cleared, because the next first beat ignores it.
  - Single-beat vector (first beat has in_last=1): result = sext(in_data), beats=1.
- Latency: the result is pushed at the clock edge of the closing beat, so out_valid=1 in the cycle after the closing beat when the FIFO was empty. Back-to-back vectors (last beat followed immediately by a new first beat) are supported without a bubble.
- FIFO: 2 entries, registered outputs. out_data/out_beats show the head and are stable while out_valid=1 and out_ready=0.
  - Pop when out_valid&out_ready.
  - Push while full and popping in the same cycle is accepted.
  - Push while full without a pop: the new result is dropped, overrun<=1, and existing entries are unchanged.
  - Empty FIFO: out_valid=0; out_data holds its last value (not checked).
- Arithmetic: two's-complement wrap at W_ACC. Cannot overflow within MAX_BEATS beats.
- Sticky flags: err_clr=1 clears overrun/len_err.
  - If a set event and err_clr occur in the same cycle, the set wins.
  - Flags never affect data flow.
- in_last with in_valid=0 is ignored.

Test Plan:
- Reset, then 4 beats in_data=10,20,30,40 with last on the 4th, out_ready=1. Expect out_valid the cycle after beat 4, out_data=100, out_beats=4, a one-cycle pulse.
- Signed input: 3 beats of 0x3FFFF (-1) with last on the 3rd. Expect out_data=-3 (0xFFFFFD), out_beats=3.
- Back-to-back vectors: single-beat vector {5,last}, then {7},{8,last} with no gaps, out_ready=0. Expect FIFO holds 5/beats1 then 15/beats2. Raise out_ready: two consecutive pops in order.
- Overrun: out_ready=0, three single-beat vectors 1,2,3. Expect overrun=1 after the 3rd, FIFO heads 1 then 2, and 3 lost. Then err_clr: overrun=0.
  - Repeat with out_ready=1 on the 3rd push cycle: no overrun, 3 retained.
- Length limit: 64 beats of value 1, no last. Expect result 64, out_beats=64, len_err=1. Next beat starts a fresh vector (beat 1 → acc=in_data).
- Bubbles and async reset: beats 1,_,2,_,_,3(last) with in_valid gaps → result 6. Assert rst_n low mid-vector after beats 9,9: immediate out_valid=0. After release, {4,last} → 4, beats=1.

Source files
------------

// File: rtl/dot_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator_if
// Description : Bundles the partial-sum input stream, the result output
//               stream and the sticky error flags of dot_accumulator.
//               slave  - used by the accumulator itself
//               master - used by the environment driving/consuming it
// Signals     : in_valid/in_data/in_last - partial-sum beat from adder tree
//               out_valid/out_ready      - result handshake
//               out_data/out_beats       - result at FIFO head, beat count
//               overrun/len_err/err_clr  - sticky flags and their clear
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_accumulator_if #(
  parameter int W_IN  = 18,
  parameter int CNT_W = 7,
  parameter int W_ACC = W_IN + CNT_W - 1
);
  logic              in_valid;
  logic [W_IN-1:0]   in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [W_ACC-1:0]  out_data;
  logic [CNT_W-1:0]  out_beats;
  logic              overrun;
  logic              len_err;
  logic              err_clr;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, err_clr,
    output out_valid, out_data, out_beats, overrun, len_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, err_clr,
    input  out_valid, out_data, out_beats, overrun, len_err
  );
endinterface
`default_nettype wire

// File: rtl/dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator
// Description : Sums per-cycle partial sums from the adder tree over a vector
//               (closed by in_last or by hitting MAX_BEATS) and queues each
//               dot-product result in a 2-entry output FIFO. The upstream has
//               no backpressure, so a result arriving at a full FIFO is
//               dropped and flagged as an overrun.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - dot_accumulator_if.slave (input stream, output
//                       stream, sticky flags, flag clear)
// Revision    : 1.0 - initial release
// ============================================================================
module dot_accumulator #(
  parameter int W_IN      = 18,
  parameter int MAX_BEATS = 64,
  parameter int CNT_W     = 7,
  parameter int W_ACC     = W_IN + CNT_W - 1
) (
  input  wire                  clk,
  input  wire                  rst_n,
  dot_accumulator_if.slave     bus
);

  localparam logic [CNT_W-1:0] c_MAX_BEATS = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Accumulator
  // --------------------------------------------------------------------------
  logic [W_ACC-1:0] r_acc;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [W_ACC-1:0] w_sext;
  logic [W_ACC-1:0] w_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_close;
  logic             w_forced;

  assign w_sext    = {{(W_ACC-W_IN){bus.in_data[W_IN-1]}}, bus.in_data};
  // A zero beat count marks the first beat, so a stale r_acc is ignored and
  // the accumulator never needs an explicit clear on close.
  assign w_nxt     = ((r_beat_cnt == '0) ? '0 : r_acc) + w_sext;
  assign w_cnt_inc = r_beat_cnt + c_ONE;
  assign w_close   = bus.in_valid && (bus.in_last || (w_cnt_inc == c_MAX_BEATS));
  assign w_forced  = w_close && !bus.in_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
    end else if (bus.in_valid) begin
      r_acc      <= w_nxt;
      r_beat_cnt <= w_close ? '0 : w_cnt_inc;
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry output FIFO as head + tail registers; the head drives the outputs
  // directly so out_data/out_beats come straight from flops.
  // --------------------------------------------------------------------------
  logic             r_h_valid;
  logic [W_ACC-1:0] r_h_data;
  logic [CNT_W-1:0] r_h_beats;
  logic             r_t_valid;
  logic [W_ACC-1:0] r_t_data;
  logic [CNT_W-1:0] r_t_beats;

  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_drop;

  assign w_pop     = r_h_valid && bus.out_ready;
  assign w_full    = r_h_valid && r_t_valid;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign w_push_ok = w_close && (!w_full || w_pop);
  assign w_drop    = w_close && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_valid <= 1'b0;
      r_h_data  <= '0;
      r_h_beats <= '0;
      r_t_valid <= 1'b0;
      r_t_data  <= '0;
      r_t_beats <= '0;
    end else if (w_pop) begin
      if (r_t_valid) begin
        // Tail moves up; the new result (if any) becomes the tail.
        r_h_data  <= r_t_data;
        r_h_beats <= r_t_beats;
        r_h_valid <= 1'b1;
        r_t_valid <= w_push_ok;
        if (w_push_ok) begin
          r_t_data  <= w_nxt;
          r_t_beats <= w_cnt_inc;
        end
      end else begin
        // Head leaves; head data is left as-is when nothing replaces it.
        r_h_valid <= w_push_ok;
        if (w_push_ok) begin
          r_h_data  <= w_nxt;
          r_h_beats <= w_cnt_inc;
        end
      end
    end else if (w_push_ok) begin
      if (!r_h_valid) begin
        r_h_valid <= 1'b1;
        r_h_data  <= w_nxt;
        r_h_beats <= w_cnt_inc;
      end else begin
        r_t_valid <= 1'b1;
        r_t_data  <= w_nxt;
        r_t_beats <= w_cnt_inc;
      end
    end
  end

  assign bus.out_valid = r_h_valid;
  assign bus.out_data  = r_h_data;
  assign bus.out_beats = r_h_beats;

  // --------------------------------------------------------------------------
  // Sticky error flags; a set event in the same cycle as err_clr wins.
  // --------------------------------------------------------------------------
  logic r_overrun;
  logic r_len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_forced) begin
        r_len_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_len_err <= 1'b0;
      end
    end
  end

  assign bus.overrun = r_overrun;
  assign bus.len_err = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_accumulator
// Description : Self-checking bench for dot_accumulator. A reference model
//               computes each vector's result as its closing beat is driven
//               and queues it; a negedge monitor pops and compares results as
//               the DUT hands them over, and checks out_valid against the
//               expected FIFO occupancy every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_accumulator;

  localparam int W_IN      = 18;
  localparam int MAX_BEATS = 64;
  localparam int CNT_W     = 7;
  localparam int W_ACC     = W_IN + CNT_W - 1;

  typedef struct {
    logic [W_ACC-1:0] data;
    logic [CNT_W-1:0] beats;
  } result_t;

  logic clk;
  logic rst_n;

  dot_accumulator_if #(.W_IN(W_IN), .CNT_W(CNT_W), .W_ACC(W_ACC)) bus ();

  dot_accumulator #(
    .W_IN      (W_IN),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W),
    .W_ACC     (W_ACC)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  result_t          sb[$];
  logic [W_ACC-1:0] model_acc = '0;
  int               model_cnt = 0;
  logic             model_overrun = 1'b0;
  logic             model_len_err = 1'b0;

  // Result monitor: occupancy check and in-order result comparison.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (bus.out_valid !== (sb.size() != 0))
        $display("FAIL out_valid: got %b expected %b", bus.out_valid, (sb.size() != 0));
      else
        n_pass++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && sb.size() != 0) begin
        result_t e;
        e = sb.pop_front();
        n_checks++;
        if (bus.out_data !== e.data || bus.out_beats !== e.beats)
          $display("FAIL result: got data=%0h beats=%0d expected data=%0h beats=%0d",
                   bus.out_data, bus.out_beats, e.data, e.beats);
        else
          n_pass++;
      end
    end
  end

  // Drive one cycle; v=0 gives a bubble. The model is updated at the edge, after
  // the monitor has already retired any result popped in this cycle.
  task automatic beat(input logic v, input logic [W_IN-1:0] d, input logic l);
    logic [W_ACC-1:0] sx;
    logic [W_ACC-1:0] nxt;
    int               cnt;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    @(posedge clk);
    if (v) begin
      sx  = {{(W_ACC-W_IN){d[W_IN-1]}}, d};
      nxt = ((model_cnt == 0) ? '0 : model_acc) + sx;
      cnt = model_cnt + 1;
      model_acc = nxt;
      if (l || cnt == MAX_BEATS) begin
        if (sb.size() < 2) sb.push_back('{data: nxt, beats: CNT_W'(cnt)});
        else               model_overrun = 1'b1;
        if (!l) model_len_err = 1'b1;
        model_cnt = 0;
      end else begin
        model_cnt = cnt;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    else                n_pass++;
  endtask

  task automatic clear_errors();
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    model_overrun = 1'b0;
    model_len_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_beats !== '0 ||
        bus.overrun !== 1'b0 || bus.len_err !== 1'b0)
      $display("FAIL reset: got valid=%b data=%0h beats=%0d ovr=%b len=%b expected all 0",
               bus.out_valid, bus.out_data, bus.out_beats, bus.overrun, bus.len_err);
    else
      n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    beat(1, 18'd10, 0);
    beat(1, 18'd20, 0);
    beat(1, 18'd30, 0);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_early: got out_valid=%b expected 0", bus.out_valid);
    else                        n_pass++;
    beat(1, 18'd40, 1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 24'd100 || bus.out_beats !== 7'd4)
      $display("FAIL basic_sum: got valid=%b data=%0d beats=%0d expected 1/100/4",
               bus.out_valid, bus.out_data, bus.out_beats);
    else
      n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_pulse: got out_valid=%b expected 0", bus.out_valid);
    else                        n_pass++;
  endtask

  task automatic test_signed();
    bus.out_ready = 1'b1;
    beat(1, 18'h3FFFF, 0);
    beat(1, 18'h3FFFF, 0);
    beat(1, 18'h3FFFF, 1);
    n_checks++;
    if (bus.out_data !== 24'hFFFFFD || bus.out_beats !== 7'd3)
      $display("FAIL signed: got data=%0h beats=%0d expected fffffd/3", bus.out_data, bus.out_beats);
    else
      n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    beat(1, 18'd5, 1);
    beat(1, 18'd7, 0);
    beat(1, 18'd8, 1);
    repeat (2) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 24'd5 || bus.out_beats !== 7'd1)
        $display("FAIL b2b_hold: got valid=%b data=%0d beats=%0d expected 1/5/1",
                 bus.out_valid, bus.out_data, bus.out_beats);
      else
        n_pass++;
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    beat(1, 18'd1, 1);
    beat(1, 18'd2, 1);
    beat(1, 18'd3, 1);
    n_checks++;
    if (bus.overrun !== model_overrun || model_overrun !== 1'b1)
      $display("FAIL overrun_set: got overrun=%b expected 1", bus.overrun);
    else
      n_pass++;
    drain();
    clear_errors();
    n_checks++;
    if (bus.overrun !== 1'b0) $display("FAIL overrun_clr: got overrun=%b expected 0", bus.overrun);
    else                      n_pass++;
    // Third push coincides with a pop: must be accepted.
    bus.out_ready = 1'b0;
    beat(1, 18'd1, 1);
    beat(1, 18'd2, 1);
    bus.out_ready = 1'b1;
    beat(1, 18'd3, 1);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) $display("FAIL overrun_pop: got overrun=%b expected 0", bus.overrun);
    else                      n_pass++;
    drain();
  endtask

  task automatic test_length_limit();
    bus.out_ready = 1'b1;
    for (int i = 0; i < MAX_BEATS; i++) beat(1, 18'd1, 0);
    n_checks++;
    if (bus.out_data !== 24'd64 || bus.out_beats !== 7'd64 || bus.len_err !== 1'b1)
      $display("FAIL len_limit: got data=%0d beats=%0d len_err=%b expected 64/64/1",
               bus.out_data, bus.out_beats, bus.len_err);
    else
      n_pass++;
    beat(1, 18'd9, 1);
    n_checks++;
    if (bus.out_data !== 24'd9 || bus.out_beats !== 7'd1)
      $display("FAIL len_fresh: got data=%0d beats=%0d expected 9/1", bus.out_data, bus.out_beats);
    else
      n_pass++;
    drain();
    clear_errors();
    n_checks++;
    if (bus.len_err !== 1'b0) $display("FAIL len_clr: got len_err=%b expected 0", bus.len_err);
    else                      n_pass++;
  endtask

  task automatic test_bubbles_reset();
    bus.out_ready = 1'b1;
    beat(1, 18'd1, 0);
    beat(0, 18'd99, 1);
    beat(1, 18'd2, 0);
    beat(0, 18'd0, 0);
    beat(0, 18'd0, 0);
    beat(1, 18'd3, 1);
    n_checks++;
    if (bus.out_data !== 24'd6 || bus.out_beats !== 7'd3)
      $display("FAIL bubbles: got data=%0d beats=%0d expected 6/3", bus.out_data, bus.out_beats);
    else
      n_pass++;
    drain();
    bus.out_ready = 1'b0;
    beat(1, 18'd11, 1);
    beat(1, 18'd9, 0);
    beat(1, 18'd9, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0)
      $display("FAIL async_reset: got valid=%b data=%0d expected 0/0", bus.out_valid, bus.out_data);
    else
      n_pass++;
    sb.delete();
    model_cnt = 0;
    model_acc = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    beat(1, 18'd4, 1);
    n_checks++;
    if (bus.out_data !== 24'd4 || bus.out_beats !== 7'd1)
      $display("FAIL post_reset: got data=%0d beats=%0d expected 4/1", bus.out_data, bus.out_beats);
    else
      n_pass++;
    drain();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_overrun();
    test_length_limit();
    test_bubbles_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
